floo_mcast_fork_ctrl: RTL
=========================

# floo_mcast_fork_ctrl

Sequencing controller that forks one input flit stream onto several router output ports for multicast. It takes the per-flit route-select vector from the multicast destination conversion logic and drives per-port valid signals. It records which selected outputs have already accepted the flit and acknowledges the input only once every selected output has. The route set is locked from the header flit for the whole packet. It sits between the input-port route computation and the output arbiters of a multicast-capable router.

## Interface
Parameters:
- NumRoutes, 5, number of output ports; bit order North, East, South, West, Eject per floo_pkg route direction enum
- flit_t, logic, flit payload type, broadcast unchanged to all outputs
- DropCntWidth, 8, width of the saturating dropped-flit counter

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- valid_i  in  1  input flit valid
- ready_o  out  1  input flit accepted (all selected outputs served)
- data_i  in  flit_t  input flit
- last_i  in  1  flit is last of packet
- route_sel_i  in  NumRoutes  multi-hot route set, sampled on header flits only
- valid_o  out  NumRoutes  per-output valid
- ready_i  in  NumRoutes  per-output ready
- data_o  out  flit_t  flit to all outputs (equals data_i)
- busy_o  out  1  state is BURST
- drop_cnt_o  out  DropCntWidth  flits dropped due to empty route set

## Operation
- State machine states:
  - IDLE: next flit is a header.
  - BURST: inside a multi-flit packet.
- Active route set: act = route_sel_i in IDLE, route_q in BURST.
- served_q[NumRoutes]: outputs that have already taken the current flit.
- valid_o[r] = valid_i & act[r] & ~served_q[r]. It never depends on ready_i.
- hs[r] = valid_o[r] & ready_i[r].
- ready_o = valid_i & (act & ~(served_q | hs)) == 0. All selected outputs are either done or handshaking this cycle.
- Flit completion = valid_i & ready_o:
  - served_q <= 0.
  - In IDLE with last_i=0: route_q <= act, go to BURST.
  - In BURST with last_i=1: go to IDLE.
  - A single-flit packet (IDLE, last_i=1) stays in IDLE.
- Partial progress (valid_i & ~ready_o): served_q <= served_q | hs.
- Empty route set (act==0, valid_i=1):
  - ready_o=1 in the same cycle, all valid_o=0.
  - drop_cnt_o increments and saturates at all-ones.
  - State transitions follow the normal rules.
- route_sel_i changing during BURST is ignored.
- valid_i may only drop after ready_o. If it drops anyway, served_q is held and is not cleared.
- data_o = data_i, combinational.

## Timing
- Zero-cycle latency. valid_o follows valid_i combinationally. The combinational path ready_i→ready_o is permitted. There is no path from ready_i to valid_o.
- A flit occupies the input for N cycles when the slowest selected output accepts on cycle N. The minimum is 1 cycle when all outputs are ready.
- Reset values:
  - state = IDLE
  - served_q = 0
  - route_q = 0
  - drop_cnt_o = 0
  - busy_o = 0
  - ready_o = 0 while valid_i=0
- Reset mid-packet: all registers return to reset values at the next edge, and the next flit is treated as a header.
- Simultaneous handshakes on all remaining outputs in one cycle complete the flit in that cycle. served_q never has bits set outside act.

## Structure
- The route direction enum (North…Eject) and NumRoutes default come from floo_pkg. There are no new package typedefs.
- The state enum is local to the module: typedef enum logic {Idle, Burst}.
- One natural sub-module: floo_fork_served_tracker, which holds served_q plus the ready_o reduction for one flit. The FSM, route lock and counter stay in the top.

## Test plan
- Single-flit, route_sel_i=5'b10101, all ready_i=1 → valid_o=5'b10101 for 1 cycle, ready_o=1 in cycle 0, state stays IDLE.
- Single-flit, route_sel_i=5'b00110:
  - Stimulus: ready_i[1]=1 in cycle 0, ready_i[2]=1 only in cycle 3.
  - Required: valid_o=00110 in cycle 0, 00100 in cycles 1–3, ready_o=1 only in cycle 3, served_q=0 afterwards.
- 4-flit packet, header route_sel_i=5'b01001:
  - Stimulus: route_sel_i changed to 5'b10000 on flits 2–4.
  - Required: all flits go to outputs 0 and 3, busy_o=1 after the header, busy_o=0 after the last_i flit completes.
- route_sel_i=0 with valid_i=1 for 300 consecutive single flits → ready_o=1 every cycle, valid_o=0, drop_cnt_o saturates at 255.
- Mid-packet reset:
  - Stimulus: rst_ni=0 for 1 cycle during flit 2 of a 3-flit packet, with served_q=5'b00001.
  - Required: served_q=0, state IDLE, next flit uses the new route_sel_i.
- Random ready_i back-pressure, 1000 packets → each flit delivered exactly once per selected output, never to an unselected one, and valid_o[r] never deasserts before hs[r].

Source files
------------

// File: rtl/floo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : floo_pkg
// Description : Shared router types: output route directions and port count.
// Revision    : 1.0 - initial release
// ============================================================================
package floo_pkg;

  // Bit position of each output port inside a route-select vector.
  typedef enum logic [2:0] {
    North = 3'd0,
    East  = 3'd1,
    South = 3'd2,
    West  = 3'd3,
    Eject = 3'd4
  } route_direction_e;

  localparam int unsigned NumRoutes = 5;

endpackage
`default_nettype wire

// File: rtl/floo_fork_served_tracker.sv
`default_nettype none
// ============================================================================
// Module      : floo_fork_served_tracker
// Description : Remembers which selected outputs took the current flit and
//               reduces that to the input-side acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module floo_fork_served_tracker
  import floo_pkg::*;
#(
  parameter int unsigned NumRoutes = floo_pkg::NumRoutes
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [NumRoutes-1:0] act_i,
  input  logic [NumRoutes-1:0] ready_i,
  output logic [NumRoutes-1:0] valid_o,
  output logic                 ready_o
);

  logic [NumRoutes-1:0] r_served;
  logic [NumRoutes-1:0] w_hs;
  logic [NumRoutes-1:0] w_pending;

  // valid_o is deliberately independent of ready_i.
  assign valid_o   = {NumRoutes{valid_i}} & act_i & ~r_served;
  assign w_hs      = valid_o & ready_i;
  assign w_pending = act_i & ~(r_served | w_hs);
  assign ready_o   = valid_i & (w_pending == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_served <= '0;
    end else if (valid_i) begin
      // Masking with act_i keeps stale bits from surviving a route change.
      r_served <= ready_o ? '0 : ((r_served | w_hs) & act_i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/floo_mcast_fork_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : floo_mcast_fork_ctrl
// Description : Forks one input flit stream onto a multicast route set, locked
//               from the header flit for the whole packet.
// Revision    : 1.0 - initial release
// ============================================================================
module floo_mcast_fork_ctrl
  import floo_pkg::*;
#(
  parameter int unsigned NumRoutes    = floo_pkg::NumRoutes,
  parameter type         flit_t       = logic,
  parameter int unsigned DropCntWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  flit_t                   data_i,
  input  logic                    last_i,
  input  logic [NumRoutes-1:0]    route_sel_i,
  output logic [NumRoutes-1:0]    valid_o,
  input  logic [NumRoutes-1:0]    ready_i,
  output flit_t                   data_o,
  output logic                    busy_o,
  output logic [DropCntWidth-1:0] drop_cnt_o
);

  typedef enum logic {Idle, Burst} state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic                    w_route_load;
  logic [NumRoutes-1:0]    r_route;
  logic [NumRoutes-1:0]    w_act;
  logic                    w_complete;
  logic                    w_drop;
  logic [DropCntWidth-1:0] r_drop_cnt;

  assign w_act      = (r_state == Idle) ? route_sel_i : r_route;
  assign w_complete = valid_i & ready_o;
  assign w_drop     = valid_i & (w_act == '0);

  assign data_o     = data_i;
  assign busy_o     = (r_state == Burst);
  assign drop_cnt_o = r_drop_cnt;

  floo_fork_served_tracker #(
    .NumRoutes (NumRoutes)
  ) u_tracker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .act_i   (w_act),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .ready_o (ready_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= Idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_route_load = 1'b0;
    case (r_state)
      Idle: begin
        if (w_complete && !last_i) begin
          w_state_next = Burst;
          w_route_load = 1'b1;
        end
      end
      Burst: begin
        if (w_complete && last_i) begin
          w_state_next = Idle;
        end
      end
      default: w_state_next = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_route    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_route_load) begin
        r_route <= w_act;
      end
      // Saturating count of flits consumed with an empty route set.
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DropCntWidth'(1);
      end
    end
  end

endmodule
`default_nettype wire
